mem_master: RTL and testbench



---
 rtl/mem_pkg.sv | 17 +
 rtl/mem_master.sv | 153 +++++++++++++++
 tb/tb_mem_master.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared memory-interface constants and the bus-initiator state encoding.
// Used by the memory responder and by mem_master.
package mem_pkg;

  localparam int WIDTH      = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } mem_master_state_t;

endpackage : mem_pkg

// File: rtl/mem_master.sv
// Burst bus initiator: one single-cycle valid request per address, write data
// pulled from a host stream, read data pushed out as one-cycle pulses.
module mem_master
  import mem_pkg::*;
#(
  parameter int WIDTH      = mem_pkg::WIDTH,
  parameter int ADDR_WIDTH = mem_pkg::ADDR_WIDTH,
  parameter int LEN_W      = 5,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  // host command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr_rd,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  // host write-data stream
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [WIDTH-1:0]      wd_data,
  // host read-data stream
  output logic                  rd_valid,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  done,
  output logic                  err,
  // memory side (initiator view of mem_intrf)
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic [WIDTH-1:0]      rdata,
  input  logic                  ready
);

  localparam int                TCNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);

  mem_master_state_t     state_q, state_d;
  logic                  wr_rd_q, wr_rd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic                  err_q, err_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    wr_rd_d    = wr_rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    len_d      = len_q;
    tcnt_d     = tcnt_q;
    err_d      = err_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          wr_rd_d = cmd_wr_rd;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          err_d   = 1'b0;
          if (cmd_len == '0)  state_d = DONE;
          else if (cmd_wr_rd) state_d = FETCH;
          else                state_d = REQ;
        end
      end

      FETCH: begin
        if (wd_valid) begin
          wdata_d = wd_data;
          state_d = REQ;
        end
      end

      REQ: begin
        tcnt_d  = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (ready) begin
          if (!wr_rd_q) begin
            rd_data_d  = rdata;
            rd_valid_d = 1'b1;
          end
          addr_d = addr_q + ADDR_WIDTH'(1);
          len_d  = len_q - LEN_W'(1);
          if (len_q == LEN_W'(1)) state_d = DONE;
          else if (wr_rd_q)       state_d = FETCH;
          else                    state_d = REQ;
        end else begin
          // Saturating: the counter parks at TIMEOUT instead of wrapping.
          if (tcnt_q != TCNT_MAX) tcnt_d = tcnt_q + TCNT_W'(1);
          if (tcnt_d == TCNT_MAX) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_rd_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      len_q      <= '0;
      tcnt_q     <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_rd_q    <= wr_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      len_q      <= len_d;
      tcnt_q     <= tcnt_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // valid comes only from the single-cycle REQ state, so it can never be
  // high on two consecutive cycles.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign wd_ready  = (state_q == FETCH);
  assign valid     = (state_q == REQ);
  assign done      = (state_q == DONE);
  assign wr_rd     = wr_rd_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign err       = err_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule : mem_master

// File: tb/tb_mem_master.sv
// Directed bench for mem_master against a zero-wait memory responder that can
// be muted to force timeouts.
module tb_mem_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_wr_rd = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [4:0] cmd_len = '0;
  logic       wd_valid = 1'b0, wd_ready;
  logic [7:0] wd_data = '0;
  logic       rd_valid, done, err, valid, wr_rd, ready;
  logic [7:0] rd_data, wdata, rdata;
  logic [3:0] addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_master #(.WIDTH(8), .ADDR_WIDTH(4), .LEN_W(5), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr_rd(cmd_wr_rd),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
    .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready)
  );

  // Memory responder: performs an access on each cycle it samples valid=1 and
  // answers ready one cycle later; ready_en=0 mutes it.
  logic [7:0] mem [16];
  logic       ready_en = 1'b1;
  logic       mem_clr  = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
    end else begin
      ready <= valid && ready_en;
      if (valid && ready_en) begin
        if (wr_rd) mem[addr] <= wdata;
        else       rdata     <= mem[addr];
      end
    end
    if (mem_clr) for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
  end

  // Observations from the last burst
  int         b_cycles, b_valid, b_consec, b_done, b_wdr, b_stall;
  logic       b_err;
  bit         b_timed_out;
  logic [7:0] b_rdq [$];

  task automatic clear_mem();
    @(posedge clk); #1 mem_clr = 1'b1;
    @(posedge clk); #1 mem_clr = 1'b0;
  endtask

  // Runs one command; cycle 1 is the cycle after the accepting edge.
  // rst_at != 0 raises rst at the start of cycle rst_at+1 and returns.
  task automatic run_burst(input logic wr, input logic [3:0] a, input logic [4:0] len,
                           input int stall, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3,
                           input int rst_at, input int budget);
    logic [7:0] words [4];
    int  idx = 0, stall_left = stall, cyc = 0;
    bit  acc_next = 0, accepted = 0, take = 0, wdr = 0, prev_valid = 0, hit_rst = 0;
    words = '{w0, w1, w2, w3};
    b_cycles = 0; b_valid = 0; b_consec = 0; b_done = 0; b_wdr = 0; b_stall = 0;
    b_err = 1'bx; b_timed_out = 1; b_rdq.delete();
    cmd_wr_rd = wr; cmd_addr = a; cmd_len = len; cmd_valid = 1'b1;
    wd_valid  = wr && (len != 0) && (stall == 0);
    wd_data   = words[0];
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (accepted) cyc++;
      take = wd_ready && wd_valid;
      wdr  = wd_ready;
      if (!accepted && cmd_valid && cmd_ready) acc_next = 1;
      if (accepted) begin
        if (valid) b_valid++;
        if (valid && prev_valid) b_consec++;
        prev_valid = valid;
        if (wd_ready) b_wdr++;
        if (wd_ready && !wd_valid) b_stall++;
        if (rd_valid) b_rdq.push_back(rd_data);
        if (done) begin
          b_done++; b_cycles = cyc; b_err = err; b_timed_out = 0;
          break;
        end
      end
      @(posedge clk); #1;
      if (acc_next) begin accepted = 1; acc_next = 0; cmd_valid = 1'b0; end
      if (accepted && rst_at != 0 && cyc == rst_at) begin
        rst = 1'b1; b_timed_out = 0; hit_rst = 1;
        break;
      end
      if (take) begin idx++; stall_left = stall; end
      else if (wdr && stall_left > 0) stall_left--;
      wd_valid = wr && (idx < int'(len)) && (idx < 4) && (stall_left == 0);
      wd_data  = words[(idx < 4) ? idx : 3];
    end
    cmd_valid = 1'b0;
    wd_valid  = 1'b0;
    if (b_timed_out) begin
      checks++; errors++;
      $display("FAIL burst_timeout: no done within %0d cycles (addr %0h len %0d)", budget, a, len);
    end else if (!hit_rst) begin
      repeat (2) begin
        @(negedge clk);
        if (done)  b_done++;
        if (valid) b_valid++;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] obs [10];
    string      nm  [10];
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs = '{8'(cmd_ready), 8'(wd_ready), 8'(rd_valid), rd_data, 8'(done),
            8'(err), 8'(valid), 8'(wr_rd), 8'(addr), wdata};
    nm  = '{"cmd_ready", "wd_ready", "rd_valid", "rd_data", "done",
            "err", "valid", "wr_rd", "addr", "wdata"};
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs[i] !== 8'h00) begin
        errors++; $display("FAIL reset_%s: got %0h expected 0", nm[i], obs[i]);
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_zero_len();
    run_burst(1'b1, 4'h5, 5'd0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 50);
    checks++; if (b_cycles !== 1) begin errors++; $display("FAIL zero_done_latency: got %0d expected 1", b_cycles); end
    checks++; if (b_done !== 1)   begin errors++; $display("FAIL zero_done_count: got %0d expected 1", b_done); end
    checks++; if (b_valid !== 0)  begin errors++; $display("FAIL zero_valid: got %0d expected 0", b_valid); end
    checks++; if (b_wdr !== 0)    begin errors++; $display("FAIL zero_wd_ready: got %0d expected 0", b_wdr); end
    checks++; if (b_rdq.size() !== 0) begin errors++; $display("FAIL zero_rd_valid: got %0d expected 0", b_rdq.size()); end
  endtask

  task automatic test_write_read();
    logic [7:0] exp_rd [3];
    exp_rd = '{8'hA1, 8'hA2, 8'hA3};
    clear_mem();
    run_burst(1'b1, 4'h3, 5'd3, 0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 0, 100);
    checks++; if (b_cycles !== 10) begin errors++; $display("FAIL wr_latency: got %0d expected 10", b_cycles); end
    checks++; if (b_done !== 1)    begin errors++; $display("FAIL wr_done_count: got %0d expected 1", b_done); end
    checks++; if (b_valid !== 3)   begin errors++; $display("FAIL wr_valid_count: got %0d expected 3", b_valid); end
    checks++; if (b_wdr !== 3)     begin errors++; $display("FAIL wr_wd_ready_cycles: got %0d expected 3", b_wdr); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem[3+i] !== exp_rd[i]) begin errors++; $display("FAIL wr_mem[%0d]: got %0h expected %0h", 3+i, mem[3+i], exp_rd[i]); end
    end
    checks++; if (mem[6] !== 8'h00) begin errors++; $display("FAIL wr_overrun mem[6]: got %0h expected 0", mem[6]); end

    run_burst(1'b0, 4'h3, 5'd3, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 100);
    checks++; if (b_cycles !== 7)  begin errors++; $display("FAIL rd_latency: got %0d expected 7", b_cycles); end
    checks++; if (b_valid !== 3)   begin errors++; $display("FAIL rd_valid_count: got %0d expected 3", b_valid); end
    checks++; if (b_consec !== 0)  begin errors++; $display("FAIL rd_valid_back_to_back: got %0d expected 0", b_consec); end
    checks++; if (b_done !== 1)    begin errors++; $display("FAIL rd_done_count: got %0d expected 1", b_done); end
    checks++;
    if (b_rdq.size() !== 3) begin
      errors++; $display("FAIL rd_pulse_count: got %0d expected 3", b_rdq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (b_rdq[i] !== exp_rd[i]) begin errors++; $display("FAIL rd_data[%0d]: got %0h expected %0h", i, b_rdq[i], exp_rd[i]); end
      end
    end
  endtask

  task automatic test_timeout();
    ready_en = 1'b0;
    run_burst(1'b0, 4'h0, 5'd2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 100);
    ready_en = 1'b1;
    // 1 REQ cycle + 15 WAIT cycles, then DONE
    checks++; if (b_cycles !== 17) begin errors++; $display("FAIL to_done_latency: got %0d expected 17", b_cycles); end
    checks++; if (b_err !== 1'b1)  begin errors++; $display("FAIL to_err_at_done: got %b expected 1", b_err); end
    checks++; if (b_valid !== 1)   begin errors++; $display("FAIL to_valid_count: got %0d expected 1", b_valid); end
    checks++; if (b_done !== 1)    begin errors++; $display("FAIL to_done_count: got %0d expected 1", b_done); end
    checks++; if (b_rdq.size() !== 0) begin errors++; $display("FAIL to_rd_valid: got %0d expected 0", b_rdq.size()); end
    checks++; if (err !== 1'b1)    begin errors++; $display("FAIL to_err_sticky: got %b expected 1", err); end
    run_burst(1'b0, 4'h3, 5'd1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 50);
    checks++; if (b_err !== 1'b0)  begin errors++; $display("FAIL to_err_cleared: got %b expected 0", b_err); end
    checks++;
    if (b_rdq.size() !== 1 || b_rdq[0] !== 8'hA1) begin
      errors++; $display("FAIL to_next_read: got %0d beats first %0h expected 1 beat A1", b_rdq.size(), (b_rdq.size() > 0) ? b_rdq[0] : 8'hxx);
    end
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    // rst rises at the start of cycle 4: WAIT of beat 2
    run_burst(1'b0, 4'h3, 5'd4, 0, 8'h00, 8'h00, 8'h00, 8'h00, 3, 50);
    checks++; if (b_rdq.size() !== 1) begin errors++; $display("FAIL rm_beats_before_reset: got %0d expected 1", b_rdq.size()); end
    @(negedge clk);
    if (done) done_seen++;
    @(posedge clk); #1;
    @(negedge clk);
    if (done) done_seen++;
    checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL rm_valid: got %b expected 0", valid); end
    checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL rm_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rm_cmd_ready_in_reset: got %b expected 0", cmd_ready); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL rm_err: got %b expected 0", err); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    if (done) done_seen++;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_idle_after_reset: got %b expected 1", cmd_ready); end
    checks++; if (done_seen !== 0)    begin errors++; $display("FAIL rm_no_done: got %0d expected 0", done_seen); end
    run_burst(1'b0, 4'h4, 5'd2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 50);
    checks++; if (b_cycles !== 5) begin errors++; $display("FAIL rm_next_latency: got %0d expected 5", b_cycles); end
    checks++;
    if (b_rdq.size() !== 2 || b_rdq[0] !== 8'hA2 || b_rdq[1] !== 8'hA3) begin
      errors++; $display("FAIL rm_next_read: got %0d beats expected A2,A3", b_rdq.size());
    end
  endtask

  task automatic test_wrap_stall();
    logic [7:0] exp_w [4];
    logic [3:0] exp_a [4];
    exp_w = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    exp_a = '{4'hE, 4'hF, 4'h0, 4'h1};
    clear_mem();
    run_burst(1'b1, 4'hE, 5'd4, 3, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 0, 300);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[exp_a[i]] !== exp_w[i]) begin errors++; $display("FAIL wrap_mem[%0h]: got %0h expected %0h", exp_a[i], mem[exp_a[i]], exp_w[i]); end
    end
    checks++; if (mem[2] !== 8'h00)  begin errors++; $display("FAIL wrap_overrun mem[2]: got %0h expected 0", mem[2]); end
    checks++; if (b_valid !== 4)     begin errors++; $display("FAIL wrap_valid_count: got %0d expected 4", b_valid); end
    checks++; if (b_stall !== 12)    begin errors++; $display("FAIL wrap_stall_cycles: got %0d expected 12", b_stall); end
    checks++; if (b_cycles !== 25)   begin errors++; $display("FAIL wrap_latency: got %0d expected 25", b_cycles); end
    checks++; if (b_consec !== 0)    begin errors++; $display("FAIL wrap_valid_back_to_back: got %0d expected 0", b_consec); end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_write_read();
    test_timeout();
    test_reset_mid();
    test_wrap_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_master
